// File: rtl/window_3x3_gen_pkg.sv
// Shared constants and types for the 3x3 sliding-window generator.
package window_3x3_gen_pkg;

  localparam int unsigned PIX_W = 24;

  // Channel bit positions within a packed RGB pixel.
  localparam int unsigned RMsb = 23;
  localparam int unsigned RLsb = 16;
  localparam int unsigned GMsb = 15;
  localparam int unsigned GLsb = 8;
  localparam int unsigned BMsb = 7;
  localparam int unsigned BLsb = 0;

  typedef enum logic [1:0] {
    StWaitSof,
    StFill,
    StActive,
    StDone
  } state_e;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-line pixel memory: one write port, one registered read port, read-before-write.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 RGB window generator over a raster stream, backed by two line memories.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  output logic [PIX_W-1:0] colour_o0,
  output logic [PIX_W-1:0] colour_o1,
  output logic [PIX_W-1:0] colour_o2,
  output logic [PIX_W-1:0] colour_o3,
  output logic [PIX_W-1:0] colour_o4,
  output logic [PIX_W-1:0] colour_o5,
  output logic [PIX_W-1:0] colour_o6,
  output logic [PIX_W-1:0] colour_o7,
  output logic [PIX_W-1:0] colour_o8,
  output logic             win_valid_o,
  output logic             frame_done_o
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [PIX_W-1:0]  win_q [9];
  logic [PIX_W-1:0]  win_d [9];
  logic [PIX_W-1:0]  colour_q [9];
  logic [PIX_W-1:0]  colour_d [9];
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              wr_en;
  logic [ColW-1:0]   wr_addr;
  logic [PIX_W-1:0]  line0_rd, line1_rd;
  logic              restart, take;

  assign restart = pix_valid_i & sof_i;
  assign take    = pix_valid_i & ~sof_i & ((state_q == StFill) | (state_q == StActive));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = col_q;
    if (restart) begin
      state_d = StFill;
      col_d   = ColW'(1);
      row_d   = '0;
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (take) begin
      wr_en       = 1'b1;
      win_valid_d = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      if (state_q == StFill && row_q == RowW'(2) && col_q == '0) begin
        state_d = StActive;
      end
      if (row_q == RowLast && col_q == ColLast) begin
        state_d      = StDone;
        frame_done_d = 1'b1;
        row_d        = '0;
        col_d        = '0;
      end
    end else if (state_q == StDone) begin
      state_d = StWaitSof;
    end
  end

  // Shift left one column; new right column is {older line, newer line, live pixel}.
  always_comb begin
    win_d    = win_q;
    colour_d = colour_q;
    if (wr_en) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = line1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = line0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_i;
    end
    if (win_valid_d) begin
      colour_d = win_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitSof;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i]    <= '0;
        colour_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      colour_q     <= colour_d;
    end
  end

  // Read address runs one pixel ahead so the registered read lands with the pixel.
  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(PIX_W)
  ) u_line0 (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (pix_i),
    .rd_addr_i (col_d),
    .rd_data_o (line0_rd)
  );

  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(PIX_W)
  ) u_line1 (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (line0_rd),
    .rd_addr_i (col_d),
    .rd_data_o (line1_rd)
  );

  assign colour_o0    = colour_q[0];
  assign colour_o1    = colour_q[1];
  assign colour_o2    = colour_q[2];
  assign colour_o3    = colour_q[3];
  assign colour_o4    = colour_q[4];
  assign colour_o5    = colour_q[5];
  assign colour_o6    = colour_q[6];
  assign colour_o7    = colour_q[7];
  assign colour_o8    = colour_q[8];
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 frame with pixel (r,c) = {3{r*16+c}}.
module tb_window_3x3_gen;
  import window_3x3_gen_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic             clk;
  logic             rst_n;
  logic [PIX_W-1:0] pix_i;
  logic             pix_valid_i;
  logic             sof_i;
  logic [PIX_W-1:0] colour_o0, colour_o1, colour_o2, colour_o3, colour_o4;
  logic [PIX_W-1:0] colour_o5, colour_o6, colour_o7, colour_o8;
  logic             win_valid_o;
  logic             frame_done_o;
  logic [215:0]     got_win;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  win_seen = 0;
  int unsigned  done_req = 0;
  int unsigned  done_ack = 0;
  logic [215:0] exp_q [$];
  logic [215:0] last_exp = '0;

  window_3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_i        (pix_i),
    .pix_valid_i  (pix_valid_i),
    .sof_i        (sof_i),
    .colour_o0    (colour_o0),
    .colour_o1    (colour_o1),
    .colour_o2    (colour_o2),
    .colour_o3    (colour_o3),
    .colour_o4    (colour_o4),
    .colour_o5    (colour_o5),
    .colour_o6    (colour_o6),
    .colour_o7    (colour_o7),
    .colour_o8    (colour_o8),
    .win_valid_o  (win_valid_o),
    .frame_done_o (frame_done_o)
  );

  assign got_win = {colour_o8, colour_o7, colour_o6, colour_o5, colour_o4,
                    colour_o3, colour_o2, colour_o1, colour_o0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pv(input int r, input int c);
    logic [7:0]       v;
    logic [PIX_W-1:0] p;
    v = 8'(r * 16 + c);
    p = '0;
    p[RMsb:RLsb] = v;
    p[GMsb:GLsb] = v;
    p[BMsb:BLsb] = v;
    return p;
  endfunction

  // Golden window ending at (r,c), packed with o0 in the low bits.
  function automatic logic [215:0] exp_win(input int r, input int c);
    logic [215:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[k*24 +: 24] = pv(r - 2 + k / 3, c - 2 + k % 3);
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid_i = 1'b0;
      sof_i       = 1'b0;
      pix_i       = '0;
    end
  endtask

  task automatic send(input int r, input int c, input bit sof, input bit counted, input int gap);
    idle(gap);
    @(negedge clk);
    pix_i       = pv(r, c);
    pix_valid_i = 1'b1;
    sof_i       = sof;
    if (counted && r >= 2 && c >= 2) exp_q.push_back(exp_win(r, c));
    if (counted && r == H - 1 && c == W - 1) done_req++;
  endtask

  // Sends pixels 0..last_idx of a frame in raster order, sof on the first.
  task automatic send_frame(input int last_idx, input int gapmax);
    for (int i = 0; i <= last_idx; i++) begin
      send(i / W, i % W, i == 0, 1'b1, int'($urandom_range(gapmax, 0)));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) last_exp = '0;
    check("frame_done", 216'(frame_done_o), 216'(done_req != done_ack));
    done_ack = done_req;
    if (win_valid_o) win_seen++;
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check("win_valid", 216'(win_valid_o), 216'(1));
      check("window", got_win, last_exp);
    end else begin
      check("win_valid", 216'(win_valid_o), 216'(0));
      check("hold", got_win, last_exp);
    end
  end

  initial begin
    int base;
    rst_n       = 1'b0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_colour", got_win, '0);
    check("rst_valid", 216'(win_valid_o), '0);
    check("rst_done", 216'(frame_done_o), '0);
    rst_n = 1'b1;
    idle(2);

    // Pixels before any sof are discarded.
    for (int i = 0; i < 6; i++) send(2 + i / 4, i % 4, 1'b0, 1'b0, 0);
    idle(2);
    check("pre_sof_cnt", 216'(win_seen), 216'(0));

    base = int'(win_seen);
    send_frame(15, 0);
    idle(3);
    check("contig_cnt", 216'(win_seen - base), 216'(4));

    base = int'(win_seen);
    send_frame(15, 3);
    idle(3);
    check("gap_cnt", 216'(win_seen - base), 216'(4));

    // After frame_done the FSM waits for sof again.
    base = int'(win_seen);
    for (int i = 0; i < 5; i++) send(2 + i / 4, i % 4, 1'b0, 1'b0, 0);
    idle(3);
    check("post_done_cnt", 216'(win_seen - base), 216'(0));

    // Abort frame A at (2,1) with a fresh sof.
    base = int'(win_seen);
    send_frame(8, 0);
    send_frame(15, 0);
    idle(3);
    check("abort_cnt", 216'(win_seen - base), 216'(4));

    // Reset in place of pixel (2,3).
    base = int'(win_seen);
    send_frame(10, 0);
    @(negedge clk);
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("midrst_colour", got_win, '0);
    check("midrst_valid", 216'(win_valid_o), '0);
    check("midrst_done", 216'(frame_done_o), '0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(2 + i / 4, i % 4, 1'b0, 1'b0, 0);
    send_frame(15, 0);
    idle(3);
    check("midrst_cnt", 216'(win_seen - base), 216'(5));

    // Back-to-back frames, second sof in the cycle after frame_done.
    base = int'(win_seen);
    send_frame(15, 0);
    idle(1);
    send_frame(15, 0);
    idle(3);
    check("b2b_cnt", 216'(win_seen - base), 216'(8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
